// File: rtl/spkr_pwm_out_if.sv
// Sample stream interface between the speaker controller (producer) and the
// PWM output stage (consumer). Valid/ready: a sample transfers on any ACLK
// edge where s_tvalid and s_tready are both high.
//   s_tdata  : signed PCM sample, two's complement
//   s_tvalid : producer has a sample on s_tdata
//   s_tready : consumer can take a sample (registered in the consumer)
interface spkr_pwm_out_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] s_tdata;
  logic                    s_tvalid;
  logic                    s_tready;

  modport master (output s_tdata, output s_tvalid, input  s_tready);
  modport slave  (input  s_tdata, input  s_tvalid, output s_tready);
endinterface

// File: rtl/spkr_pwm_out.sv
// Speaker PWM output stage. Buffers signed PCM samples in a small FIFO,
// consumes one per programmable sample period and turns the top PWM_BITS of
// each sample into the duty of a free-running PWM driving the speaker pin.
// Ports:
//   ACLK, ARESETN  : clock, synchronous active-low reset
//   enable         : 1 = run, 0 = idle (FIFO flushed, pin low, amp off)
//   sample_div     : clocks per sample period (0 and 1 both mean every clock)
//   s              : sample stream (slave side of spkr_pwm_out_if)
//   pwm_out        : PWM to the speaker amplifier
//   amp_en         : amplifier enable, high while running
//   underrun       : one-cycle pulse when a sample period ends with no data
//   underrun_count : saturating count of underruns since entering run
//   fifo_count     : FIFO occupancy
module spkr_pwm_out #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int PWM_BITS     = 8,
  parameter int FIFO_DEPTH   = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                enable,
  input  logic [15:0]         sample_div,
  spkr_pwm_out_if.slave       s,
  output logic                pwm_out,
  output logic                amp_en,
  output logic                underrun,
  output logic [15:0]         underrun_count,
  output logic [CW-1:0]       fifo_count
);

  localparam logic [PWM_BITS-1:0] MID  = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [CW-1:0]       FULL = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt_d;
  logic                    tready_q;
  logic [PWM_BITS-1:0]     duty, pwm_cnt;
  logic [15:0]             tmr_q, term_q, div_term;
  logic                    run_act, entering, tick, empty, push, pop;
  logic [SAMPLE_WIDTH-1:0] head;

  assign s.s_tready = tready_q;

  // run_act: running this cycle and staying in RUN; the cycle enable drops
  // behaves like idle so the flush wins over any push or pop.
  assign run_act  = (state_q == RUN) && enable;
  assign entering = (state_q == IDLE) && enable;
  assign div_term = (sample_div == 16'd0) ? 16'd0 : sample_div - 16'd1;
  assign tick     = run_act && (tmr_q == term_q);
  assign empty    = (fifo_count == '0);
  assign push     = run_act && s.s_tvalid && tready_q;
  // Pop uses the occupancy before this cycle's push, so a push into an
  // empty FIFO on a tick still counts as an underrun.
  assign pop      = tick && !empty;
  assign head     = mem[rd_ptr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable)  state_d = RUN;
      RUN:  if (!enable) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (run_act) begin
      case ({push, pop})
        2'b10:   cnt_d = fifo_count + CW'(1);
        2'b01:   cnt_d = fifo_count - CW'(1);
        default: cnt_d = fifo_count;
      endcase
    end
  end

  // Sample storage carries no reset; pointers and count define validity.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= s.s_tdata;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q        <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      tready_q       <= 1'b0;
      amp_en         <= 1'b0;
      pwm_out        <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      duty           <= MID;
      pwm_cnt        <= '0;
      tmr_q          <= '0;
      term_q         <= '0;
    end else begin
      state_q    <= state_d;
      fifo_count <= cnt_d;
      amp_en     <= (state_d == RUN);
      // Registered ready looks one cycle ahead using the next occupancy.
      tready_q   <= (state_d == RUN) && (cnt_d != FULL);
      underrun   <= tick && empty;

      if (!run_act) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        pwm_cnt <= '0;
        pwm_out <= 1'b0;
        tmr_q   <= '0;
        term_q  <= div_term;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        pwm_out <= (pwm_cnt < duty);
        // Divisor is re-latched only at wrap so a change never truncates
        // or stretches the period in flight.
        if (tmr_q == term_q) begin
          tmr_q  <= '0;
          term_q <= div_term;
        end else begin
          tmr_q  <= tmr_q + 16'd1;
        end
        // Signed to offset binary: flip the MSB of the top PWM_BITS.
        if (pop) duty <= head[SAMPLE_WIDTH-1 -: PWM_BITS] ^ MID;
        if (tick && empty && (underrun_count != 16'hFFFF))
          underrun_count <= underrun_count + 16'd1;
      end

      if (entering) begin
        underrun_count <= '0;
        duty           <= MID;
      end
    end
  end

endmodule

// File: tb/tb_spkr_pwm_out.sv
// Self-checking bench for spkr_pwm_out. Expected duty/high-time values come
// from the offset-binary rule applied to the samples the bench accepted, and
// timing expectations from the tick schedule (tick at run cycle k*div).
module tb_spkr_pwm_out;
  logic        ACLK = 1'b0;
  logic        ARESETN, enable;
  logic [15:0] sample_div;
  logic        pwm_out, amp_en, underrun;
  logic [15:0] underrun_count;
  logic [4:0]  fifo_count;

  spkr_pwm_out_if #(.SAMPLE_WIDTH(16)) s_if();

  spkr_pwm_out #(.SAMPLE_WIDTH(16), .PWM_BITS(8), .FIFO_DEPTH(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .sample_div(sample_div),
    .s(s_if.slave), .pwm_out(pwm_out), .amp_en(amp_en), .underrun(underrun),
    .underrun_count(underrun_count), .fifo_count(fifo_count)
  );

  always #5 ACLK = ~ACLK;

  int          n_pass = 0;
  int          n_total = 0;
  int          rc = 0;          // run cycle index, 1 = first cycle in RUN
  bit          auto_inc = 1'b0;
  logic [15:0] sb[$];           // samples accepted by the DUT, in order

  function automatic logic [7:0] conv(input logic [15:0] smp);
    return {~smp[15], smp[14:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock; records a handshake that completes on this edge.
  task automatic cyc();
    bit acc;
    acc = (s_if.s_tvalid === 1'b1) && (s_if.s_tready === 1'b1);
    @(posedge ACLK);
    #1;
    rc++;
    if (acc) begin
      sb.push_back(s_if.s_tdata);
      if (auto_inc) s_if.s_tdata = s_if.s_tdata + 16'h0100;
    end
  endtask

  task automatic goto(input int c);
    while (rc < c) cyc();
  endtask

  task automatic meas(output int h);
    h = 0;
    repeat (256) begin
      cyc();
      h += int'(pwm_out);
    end
  endtask

  initial begin
    int h, n, m, idx;
    int e2[3] = '{0, 128, 255};

    // Reset state
    ARESETN = 1'b0; enable = 1'b0; sample_div = 16'd4;
    s_if.s_tvalid = 1'b0; s_if.s_tdata = '0;
    repeat (3) cyc();
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_amp", 32'(amp_en), 0);
    chk("rst_tready", 32'(s_if.s_tready), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ucnt", 32'(underrun_count), 0);
    chk("rst_fifo", 32'(fifo_count), 0);
    ARESETN = 1'b1;
    cyc();

    // 1: run with no data, div 4
    enable = 1'b1; rc = 0; cyc();
    chk("t1_amp", 32'(amp_en), 1);
    chk("t1_tready", 32'(s_if.s_tready), 1);
    n = 0;
    repeat (40) begin cyc(); n += int'(underrun); end
    chk("t1_pulses", 32'(n), 10);
    chk("t1_ucnt", 32'(underrun_count), 10);
    meas(h);
    chk("t1_mid_high", 32'(h), 128);
    enable = 1'b0; cyc();
    chk("t1_off_amp", 32'(amp_en), 0);
    chk("t1_off_pwm", 32'(pwm_out), 0);

    // 2: directed duty values, div 1024
    sample_div = 16'd1024; enable = 1'b1; rc = 0; cyc();
    sb.delete();
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata = 16'h8000; cyc();
    s_if.s_tdata = 16'h0000; cyc();
    s_if.s_tdata = 16'h7FFF; cyc();
    s_if.s_tvalid = 1'b0;
    chk("t2_fifo", 32'(fifo_count), 3);
    for (int k = 1; k <= 3; k++) begin
      goto(1024 * k + 1);
      chk("t2_fifo_pop", 32'(fifo_count), 32'(3 - k));
      meas(h);
      chk("t2_high", 32'(h), 32'(e2[k-1]));
    end
    goto(4097);
    chk("t2_underrun", 32'(underrun), 1);
    chk("t2_ucnt", 32'(underrun_count), 1);
    meas(h);
    chk("t2_hold_high", 32'(h), 255);
    enable = 1'b0; cyc();

    // Random samples with random valid gaps, div 256
    sample_div = 16'd256; enable = 1'b1; rc = 0; cyc();
    sb.delete();
    n = $urandom_range(3, 6);
    while (sb.size() < n && rc < 200) begin
      s_if.s_tvalid = 1'($urandom_range(0, 1));
      s_if.s_tdata  = 16'($urandom);
      cyc();
    end
    s_if.s_tvalid = 1'b0;
    m = sb.size();
    chk("rnd_pushes", 32'(m), 32'(n));
    chk("rnd_fifo", 32'(fifo_count), 32'(n));
    for (int k = 1; k <= m + 1; k++) begin
      goto(256 * k + 1);
      chk("rnd_ucnt", 32'(underrun_count), (k == m + 1) ? 1 : 0);
      meas(h);
      idx = (k <= m) ? k - 1 : m - 1;
      chk("rnd_high", 32'(h), 32'(conv(sb[idx])));
    end
    enable = 1'b0; cyc();

    // 3: backpressure with incrementing data, div 1000
    sample_div = 16'd1000; enable = 1'b1; rc = 0; cyc();
    sb.delete();
    s_if.s_tdata = 16'h0000; auto_inc = 1'b1; s_if.s_tvalid = 1'b1;
    goto(25);
    chk("t3_full", 32'(fifo_count), 16);
    chk("t3_tready_low", 32'(s_if.s_tready), 0);
    chk("t3_acc16", 32'(sb.size()), 16);
    goto(1010);
    chk("t3_acc17", 32'(sb.size()), 17);
    chk("t3_full2", 32'(fifo_count), 16);
    s_if.s_tvalid = 1'b0; auto_inc = 1'b0;
    sample_div = 16'd256;   // applies from the wrap at run cycle 2000
    goto(1100);
    meas(h);
    chk("t3_s0", 32'(h), 32'(conv(sb[0])));
    for (int j = 1; j < 17; j++) begin
      goto(2000 + 256 * (j - 1) + 1);
      meas(h);
      chk("t3_seq", 32'(h), 32'(conv(sb[j])));
    end
    goto(2000 + 256 * 16 + 1);
    chk("t3_ucnt", 32'(underrun_count), 1);

    // 4: disable with 10 queued, then re-enable
    s_if.s_tdata = 16'h4000; auto_inc = 1'b1; s_if.s_tvalid = 1'b1;
    repeat (10) cyc();
    s_if.s_tvalid = 1'b0; auto_inc = 1'b0;
    chk("t4_fifo10", 32'(fifo_count), 10);
    enable = 1'b0; cyc();
    chk("t4_fifo0", 32'(fifo_count), 0);
    chk("t4_pwm", 32'(pwm_out), 0);
    chk("t4_amp", 32'(amp_en), 0);
    chk("t4_tready", 32'(s_if.s_tready), 0);
    chk("t4_ucnt_hold", 32'(underrun_count), 1);
    enable = 1'b1; rc = 0; cyc();
    chk("t4_ucnt_clr", 32'(underrun_count), 0);
    chk("t4_amp_on", 32'(amp_en), 1);
    meas(h);
    chk("t4_mid_high", 32'(h), 128);

    // 5: reset mid-stream with 5 queued
    s_if.s_tvalid = 1'b1; repeat (5) cyc(); s_if.s_tvalid = 1'b0;
    chk("t5_fifo5", 32'(fifo_count), 5);
    ARESETN = 1'b0; cyc();
    chk("t5_fifo", 32'(fifo_count), 0);
    chk("t5_amp", 32'(amp_en), 0);
    chk("t5_pwm", 32'(pwm_out), 0);
    chk("t5_tready", 32'(s_if.s_tready), 0);
    chk("t5_underrun", 32'(underrun), 0);
    chk("t5_ucnt", 32'(underrun_count), 0);
    ARESETN = 1'b1; enable = 1'b0; cyc();

    // 6: underrun counter saturation, div 1
    sample_div = 16'd1; enable = 1'b1; rc = 0; cyc();
    goto(65535);
    chk("t6_ucnt_pre", 32'(underrun_count), 65534);
    cyc();
    chk("t6_ucnt_sat", 32'(underrun_count), 65535);
    goto(66000);
    chk("t6_ucnt_hold", 32'(underrun_count), 65535);
    chk("t6_pulse", 32'(underrun), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spkr_pwm_out.md
Name: spkr_pwm_out

Overview:
Downstream output stage of the speaker peripheral controller. Takes signed PCM samples from the controller's register/stream side over a valid/ready interface and buffers them in a small FIFO. Samples are consumed at a programmable sample rate. Each sample drives a free-running PWM that feeds the speaker amplifier pin, plus an amplifier-enable output and underrun status for the controller's status registers.

Parameters:
SAMPLE_WIDTH, 16, signed PCM sample width (two's complement); must be at least PWM_BITS
PWM_BITS, 8, PWM resolution; PWM period = 2^PWM_BITS clocks
FIFO_DEPTH, 16, sample FIFO entries (power of 2, at least 2)

Ports:
ACLK  in  1  system clock
ARESETN  in  1  synchronous active-low reset
enable  in  1  run control from control register; 0 = idle and flush
sample_div  in  16  clocks per sample period; 0 and 1 both mean one sample per clock
s_tdata  in  SAMPLE_WIDTH  signed PCM sample
s_tvalid  in  1  sample valid
s_tready  out  1  sample accepted when s_tvalid and s_tready are both high at the ACLK edge
pwm_out  out  1  PWM to speaker
amp_en  out  1  amplifier enable (1 in RUN only)
underrun  out  1  one-cycle pulse: sample tick with FIFO empty
underrun_count  out  16  saturating underrun counter; cleared on reset or on entering RUN
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (ARESETN=0 at an ACLK edge): state=IDLE, FIFO empty. pwm_out=0, amp_en=0, s_tready=0, underrun=0, underrun_count=0, fifo_count=0, duty=2^(PWM_BITS-1), all counters 0. Reset mid-operation discards FIFO contents and the current PWM period.
- FSM with two states:
  - IDLE: pwm_out=0, amp_en=0, s_tready=0. FIFO is held empty. On enable=1, go to RUN next cycle. On entry, clear underrun_count, set duty=midscale, and start pwm_cnt and the sample timer from 0.
  - RUN: amp_en=1, s_tready = (fifo_count != FIFO_DEPTH). On enable=0, go to IDLE next cycle, flush the FIFO and force pwm_out=0. Samples presented in that cycle are not accepted.
- FIFO: push on s_tvalid && s_tready. When full, s_tready=0 and the producer holds its data. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Sample timer: counts 0..max(sample_div,1)-1; tick asserted when the counter reaches the terminal value, then it wraps to 0. A sample_div change takes effect at the next wrap.
- On tick with FIFO non-empty: pop the head; the next cycle, duty = top PWM_BITS of the sample with the MSB inverted (signed to offset binary). Example: 0x8000 maps to 0x00, 0x0000 to 0x80, 0x7FFF to 0xFF.
- On tick with FIFO empty: duty holds its last value; underrun pulses 1 for one cycle; underrun_count increments and saturates at 0xFFFF.
- Push into an empty FIFO on a tick cycle: the pop sees the FIFO as empty, so an underrun is flagged and the pushed sample remains queued.
- PWM: pwm_cnt is free-running, PWM_BITS wide, and wraps. pwm_out is registered: pwm_out = (pwm_cnt < duty). duty=0 gives constant 0; duty=2^PWM_BITS-1 gives high for 255 of 256 clocks.
- Latency: a sample pushed into an empty FIFO reaches duty 1 cycle after the next tick; it appears on pwm_out 1 further cycle later.
- All outputs are registered; no combinational path from s_tvalid to s_tready.

Test Plan:
1. Reset, then enable=1, no samples, sample_div=4: amp_en=1 and pwm_out 50% duty (128 of 256 clocks high). underrun pulses every 4 clocks; underrun_count reaches 10 after 40 clocks.
2. Push 0x8000, 0x0000, 0x7FFF with sample_div=1024: duty sequence 0x00, 0x80, 0xFF. Measured high time per 256-clock period is 0, 128, 255 clocks.
3. Hold s_tvalid=1 with sample_div=1000: fifo_count reaches 16 and s_tready drops to 0. After a tick, exactly one more sample is accepted; no sample is lost or duplicated (check an incrementing data pattern).
4. Drop enable to 0 with 10 samples queued: next cycle state is IDLE, fifo_count=0, pwm_out=0, amp_en=0. Re-enabling gives midscale duty and underrun_count=0.
5. Assert ARESETN=0 for one cycle mid-stream with fifo_count=5: all outputs return to reset values the following cycle.
6. Force 70000 underruns with sample_div=1: underrun_count saturates at 0xFFFF and underrun still pulses each tick.
